// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one synch_fifo write port among
// NUM_REQ producers. Keeps a credit count of FIFO occupancy so the FIFO is
// never written while full. Optional stall counter enabled by the macro
// FIFO_WR_ARB_STALL_CNT_EN (adds stall_cnt_o).
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
    input  logic                          fifo_rd_en_i,
    input  logic                          fifo_empty_i,
    output logic [CNT_WIDTH-1:0]          occ_o,
    output logic [1:0]                    state_o
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    ,
    output logic [15:0]                   stall_cnt_o
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACTIVE  = 2'b01,
        BLOCKED = 2'b10
    } state_t;

    state_t                 state_reg, state_next;
    logic [PTR_W-1:0]       ptr_reg, ptr_next;
    logic [PTR_W-1:0]       winner;
    logic                   found;
    logic                   grant;
    logic                   can_grant;
    logic                   dec;
    logic [CNT_WIDTH-1:0]   occ_reg, occ_next;
    logic                   wr_en_reg;
    logic [DATA_WIDTH-1:0]  wdata_reg;
    logic [DATA_WIDTH-1:0]  req_data [NUM_REQ];
    int                     idx;

    // Unpack the flat write-data bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_data[gi] = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Winner search, grant, credit update and next-state decode.
    always_comb begin
        found      = 1'b0;
        winner     = '0;
        idx        = 0;
        gnt_o      = '0;
        ptr_next   = ptr_reg;
        occ_next   = occ_reg;
        state_next = IDLE;

        // Reset low also masks grants so nothing is acknowledged that gets discarded.
        can_grant = rst_i && enable_i && (occ_reg < CNT_WIDTH'(DEPTH));

        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_reg) + i) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end

        grant = found && can_grant;
        if (grant) begin
            gnt_o[winner] = 1'b1;
            ptr_next      = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end

        // A read only counts if the FIFO really had data; never underflow the credit.
        dec = fifo_rd_en_i && !fifo_empty_i && (occ_reg != '0);
        if (grant && !dec) begin
            occ_next = occ_reg + 1'b1;
        end else if (!grant && dec) begin
            occ_next = occ_reg - 1'b1;
        end

        if (grant) begin
            state_next = ACTIVE;
        end else if ((req_i != '0) && enable_i && (occ_reg == CNT_WIDTH'(DEPTH))) begin
            state_next = BLOCKED;
        end
    end

    // State, pointer, credit and registered FIFO write port.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            occ_reg   <= '0;
            wr_en_reg <= 1'b0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            occ_reg   <= occ_next;
            wr_en_reg <= grant;
            wdata_reg <= grant ? req_data[winner] : '0;
        end
    end

    assign fifo_wr_en_o = wr_en_reg;
    assign fifo_wdata_o = wdata_reg;
    assign occ_o        = occ_reg;
    assign state_o      = state_reg;

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    // Count cycles spent in BLOCKED, saturating at all-ones.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == BLOCKED) && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`else
    // Stall counter not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter with a small FIFO occupancy model.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 12;
    localparam int DEPTH   = 16;
    localparam int CW      = $clog2(DEPTH + 1);

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  enable = 1'b1;
    logic [NUM_REQ-1:0]    req = '0;
    logic [NUM_REQ*DW-1:0] wdata;
    logic [NUM_REQ-1:0]    gnt;
    logic                  wr_en;
    logic [DW-1:0]         fifo_wdata;
    logic                  rd_en = 1'b0;
    logic                  fifo_empty;
    logic [CW-1:0]         occ;
    logic [1:0]            state;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0]           stall_cnt;
`endif

    logic                  force_empty = 1'b0;
    int                    fifo_size = 0;
    int                    ovf_count = 0;
    int                    checks = 0;
    int                    errors = 0;
    logic [DW-1:0]         dvec [NUM_REQ];

    always #5 clk = ~clk;

    assign wdata      = {12'h3D3, 12'h2C2, 12'h1B1, 12'h0A5};
    assign fifo_empty = force_empty || (fifo_size == 0);

    fifo_wr_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .req_i(req), .wdata_i(wdata),
        .gnt_o(gnt), .fifo_wr_en_o(wr_en), .fifo_wdata_o(fifo_wdata),
        .fifo_rd_en_i(rd_en), .fifo_empty_i(fifo_empty), .occ_o(occ), .state_o(state)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );

    // FIFO occupancy model: counts writes/reads, records any write while full.
    always @(posedge clk) begin
        if (!rst) begin
            fifo_size <= 0;
        end else begin
            if (wr_en && fifo_size >= DEPTH) ovf_count <= ovf_count + 1;
            fifo_size <= fifo_size + (wr_en ? 1 : 0) - ((rd_en && !fifo_empty) ? 1 : 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        rd_en = 1'b0;
        force_empty = 1'b0;
        enable = 1'b1;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        dvec[0] = 12'h0A5; dvec[1] = 12'h1B1; dvec[2] = 12'h2C2; dvec[3] = 12'h3D3;

        // Reset state
        do_reset();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wdata", 32'(fifo_wdata), 0);
        chk("rst_occ", 32'(occ), 0);
        chk("rst_state", 32'(state), 0);

        // Single request from requester 0
        req = 4'b0001;
        #1 chk("t1_gnt", 32'(gnt), 32'h1);
        cyc();
        req = '0;
        chk("t1_wr_en", 32'(wr_en), 1);
        chk("t1_wdata", 32'(fifo_wdata), 32'h0A5);
        chk("t1_occ", 32'(occ), 1);
        chk("t1_state", 32'(state), 1);

        // All requesting: rotation 0,1,2,3,0,1,2,3 and data order
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1 chk($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(1 << (i % 4)));
            cyc();
            chk($sformatf("rr_wr%0d", i), 32'(wr_en), 1);
            chk($sformatf("rr_data%0d", i), 32'(fifo_wdata), 32'(dvec[i % 4]));
        end
        req = '0;
        chk("rr_occ", 32'(occ), 8);

        // Fill to DEPTH, block, then one read releases one credit
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < DEPTH; i++) begin
            #1 chk($sformatf("fill_gnt%0d", i), 32'(gnt), 1);
            cyc();
        end
        chk("full_occ", 32'(occ), DEPTH);
        #1 chk("full_gnt", 32'(gnt), 0);
        cyc();
        chk("full_state", 32'(state), 2);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        for (int i = 0; i < 10; i++) cyc();
        chk("stall_cnt", 32'(stall_cnt), 10);
`endif
        rd_en = 1'b1;
        #1 chk("rd_cycle_gnt", 32'(gnt), 0);
        cyc();
        rd_en = 1'b0;
        #1 chk("resume_gnt", 32'(gnt), 1);
        chk("resume_occ", 32'(occ), DEPTH - 1);
        cyc();
        chk("refull_occ", 32'(occ), DEPTH);
        chk("resume_state", 32'(state), 1);
        #1 chk("refull_gnt", 32'(gnt), 0);
        req = '0;
        cyc();
        cyc();
        chk("no_overflow", 32'(ovf_count), 0);

        // Simultaneous grant and read; read while empty
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 5; i++) cyc();
        req = '0;
        cyc();
        chk("occ5", 32'(occ), 5);
        req = 4'b0001;
        rd_en = 1'b1;
        #1 chk("simul_gnt", 32'(gnt), 1);
        cyc();
        req = '0;
        rd_en = 1'b0;
        chk("simul_occ", 32'(occ), 5);
        rd_en = 1'b1;
        force_empty = 1'b1;
        cyc();
        rd_en = 1'b0;
        force_empty = 1'b0;
        chk("empty_rd_occ", 32'(occ), 5);
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        chk("rd_occ", 32'(occ), 4);

        // Enable low blocks grants; reset mid-burst
        enable = 1'b0;
        req = 4'b1111;
        #1 chk("dis_gnt", 32'(gnt), 0);
        cyc();
        chk("dis_state", 32'(state), 0);
        chk("dis_wr_en", 32'(wr_en), 0);
        enable = 1'b1;
        #1 chk("burst_gnt1", 32'(gnt), 32'h2);
        cyc();
        chk("burst_data1", 32'(fifo_wdata), 32'h1B1);
        #1 chk("burst_gnt2", 32'(gnt), 32'h4);
        cyc();
        rst = 1'b0;
        #1 chk("inrst_gnt", 32'(gnt), 0);
        cyc();
        chk("mrst_wr_en", 32'(wr_en), 0);
        chk("mrst_wdata", 32'(fifo_wdata), 0);
        chk("mrst_occ", 32'(occ), 0);
        chk("mrst_state", 32'(state), 0);
        rst = 1'b1;
        #1 chk("mrst_ptr_gnt", 32'(gnt), 32'h1);
        cyc();
        req = '0;
        chk("mrst_data", 32'(fifo_wdata), 32'h0A5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-side arbiter that shares one synch_fifo write port among NUM_REQ producers.
- Keeps its own credit count of FIFO occupancy, so the FIFO never sees a write while full and overflow_o never asserts.
- Sits directly in front of synch_fifo: drives its wr_en_i/wdata_i and observes the consumer's rd_en_i and the FIFO's empty_o.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 12, write data width; must match the FIFO.
- DEPTH, 16, FIFO depth; this is the credit limit.
- CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy count (derived).

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-low reset.
- enable_i  input  1  arbitration enable; low = no new grants.
- req_i  input  NUM_REQ  per-requester write request, level.
- wdata_i  input  NUM_REQ*DATA_WIDTH  packed write data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- gnt_o  output  NUM_REQ  one-hot grant; data from that requester is accepted this cycle.
- fifo_wr_en_o  output  1  to FIFO wr_en_i.
- fifo_wdata_o  output  DATA_WIDTH  to FIFO wdata_i.
- fifo_rd_en_i  input  1  copy of the consumer's FIFO rd_en_i.
- fifo_empty_i  input  1  FIFO empty_o.
- occ_o  output  CNT_WIDTH  credit occupancy count.
- state_o  output  2  FSM state.

Behaviour:
- Reset (rst_i=0 at clk edge):
  - gnt_o=0, fifo_wr_en_o=0, fifo_wdata_o=0, occ_o=0.
  - Round-robin pointer = 0; state_o=IDLE.
  - Reset mid-operation discards any in-flight write and clears credits; the FIFO is reset on the same rst_i.
- Handshake:
  - A requester holds req_i and its data stable until it sees gnt_o[k]=1.
  - The grant is the acceptance; the requester may change data or deassert req_i on the next cycle.
  - Deasserting req_i without a grant is legal; nothing is written.
- Grant (combinational from registered state):
  - Grant only when enable_i=1 and occ_q<DEPTH.
  - Winner = first k with req_i[k]=1, searching from ptr_q upward with wrap NUM_REQ-1 -> 0.
  - At most one grant per cycle.
- Pointer: on a grant, ptr_q <= (winner+1) mod NUM_REQ. With no grant the pointer holds.
- Write issue (1-cycle latency):
  - On a grant: fifo_wr_en_o <= 1 and fifo_wdata_o <= winner's data.
  - Otherwise: fifo_wr_en_o <= 0 and fifo_wdata_o <= 0.
- Credit counter:
  - inc = grant this cycle; dec = fifo_rd_en_i && !fifo_empty_i.
  - occ_q <= occ_q + inc - dec; inc and dec together leave it unchanged.
  - A read frees credit from the next cycle only; there is no same-cycle bypass.
  - occ_q never exceeds DEPTH and never wraps below 0 (dec is ignored when occ_q=0).
- FSM, state_o encoding:
  - IDLE=00: no req_i bits set, or enable_i=0.
  - ACTIVE=01: a grant is issued this cycle.
  - BLOCKED=10: req_i nonzero, enable_i=1, occ_q==DEPTH.
  - Registered, recomputed every cycle from the conditions above; BLOCKED -> ACTIVE on the cycle after a counted read.
- enable_i falling: a write already registered still reaches the FIFO; no new grants are issued.

Optional Feature:
- Macro: FIFO_WR_ARB_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o (16 bits).
  - Counts cycles in BLOCKED state, saturating at 16'hFFFF.
  - Cleared by reset.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then req_i=4'b0001, data 12'h0A5 -> gnt_o=0001 that cycle; next cycle fifo_wr_en_o=1, fifo_wdata_o=0A5; occ_o=1.
- req_i=4'b1111 held 8 cycles, no reads -> grants rotate 0,1,2,3,0,1,2,3; occ_o=8; FIFO receives data in that order.
- Req 0 only, 16 grants with no reads -> occ_o=16, state_o=BLOCKED, gnt_o=0, FIFO overflow_o stays 0. One read -> grant resumes the cycle after the read; occ_o back to 16.
- occ_o=5; simultaneous grant and counted read -> occ_o stays 5. Read with fifo_empty_i=1 -> no decrement.
- enable_i=0 with req_i=1111 -> no grants, state_o=IDLE. Reset asserted mid-burst -> all outputs 0 next cycle, pointer back to 0.
- With FIFO_WR_ARB_STALL_CNT_EN: hold BLOCKED for 10 cycles -> stall_cnt_o=10. Without the macro, the bench compiles with no stall_cnt_o port.
